// File: rtl/divmod_arbiter_pkg.sv
// Shared types and defaults for the two-requester divide/modulo arbiter.
// Tags travel alongside the external divider so returns can be steered back.
package divmod_arbiter_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int LAT_DEFAULT   = 5;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
        logic    dz;
    } tag_t;

endpackage

// File: rtl/divmod_arbiter_if.sv
// Per-requester request/response bundle; the arbiter takes one slave port per requester.
interface divmod_arbiter_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [31:0] req_dividend;
    logic [15:0] req_divisor;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_dz;

    modport master (
        output req_valid, req_mode, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_dz
    );

    modport slave (
        input  req_valid, req_mode, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_dz
    );

endinterface

// File: rtl/divmod_rsp_fifo.sv
// Synchronous response FIFO holding {dz, result}; overflow is prevented upstream by credits.
module divmod_rsp_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [32:0] push_data,
    input  logic        pop,
    output logic        empty,
    output logic [32:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [32:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/divmod_arbiter.sv
// Round-robin arbiter sharing one external pipelined divider between two requesters,
// with credit-limited per-requester response FIFOs and a tag pipeline for return steering.
module divmod_arbiter
    import divmod_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int LAT   = LAT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    divmod_arbiter_if.slave      a,
    divmod_arbiter_if.slave      b,
    output logic                 div_valid_in,
    output logic                 div_mode,
    output logic [31:0]          div_dividend,
    output logic [15:0]          div_divisor,
    input  logic                 div_valid_out,
    input  logic [31:0]          div_result,
    output logic                 busy,
    output logic                 protocol_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] out_a;
    logic [CW-1:0] out_b;
    req_id_e       last_grant;
    logic          elig_a, elig_b, grant_a, grant_b;
    logic          hs_a, hs_b, pop_a, pop_b, push_a, push_b;
    logic          empty_a, empty_b, any_tag;
    logic [32:0]   head_a, head_b;
    req_id_e       sel_id;
    logic          sel_mode;
    logic [31:0]   sel_dividend;
    logic [15:0]   sel_divisor;
    tag_t          issue_tag;
    tag_t          tags [LAT];
    tag_t          exit_tag;

    // Credits count everything not yet popped, so a full FIFO can never be overrun.
    always_comb begin
        elig_a       = a.req_valid && (out_a < CW'(DEPTH));
        elig_b       = b.req_valid && (out_b < CW'(DEPTH));
        grant_a      = elig_a && (!elig_b || (last_grant == REQ_B));
        grant_b      = elig_b && !grant_a;
        sel_id       = grant_a ? REQ_A : REQ_B;
        sel_mode     = grant_a ? a.req_mode : b.req_mode;
        sel_dividend = grant_a ? a.req_dividend : b.req_dividend;
        sel_divisor  = grant_a ? a.req_divisor : b.req_divisor;
    end

    assign a.req_ready = reset && grant_a;
    assign b.req_ready = reset && grant_b;
    assign hs_a        = a.req_valid && a.req_ready;
    assign hs_b        = b.req_valid && b.req_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_valid_in <= 1'b0;
            div_mode     <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            issue_tag    <= '0;
            last_grant   <= REQ_B;
        end else if (hs_a || hs_b) begin
            div_valid_in <= 1'b1;
            div_mode     <= sel_mode;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            issue_tag    <= '{valid: 1'b1, id: sel_id, dz: (sel_divisor == 16'd0)};
            last_grant   <= sel_id;
        end else begin
            div_valid_in <= 1'b0;
            issue_tag    <= '0;
        end
    end

    // The issue register is the first stage, so the last of these lines up with div_valid_out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= issue_tag;
            for (int i = 1; i < LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign exit_tag = tags[LAT-1];
    assign push_a   = div_valid_out && exit_tag.valid && (exit_tag.id == REQ_A);
    assign push_b   = div_valid_out && exit_tag.valid && (exit_tag.id == REQ_B);
    assign pop_a    = a.rsp_valid && a.rsp_ready;
    assign pop_b    = b.rsp_valid && b.rsp_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            protocol_err <= 1'b0;
        end else if (div_valid_out != exit_tag.valid) begin
            protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_a <= '0;
            out_b <= '0;
        end else begin
            case ({hs_a, pop_a})
                2'b10:   out_a <= out_a + CW'(1);
                2'b01:   out_a <= out_a - CW'(1);
                default: out_a <= out_a;
            endcase
            case ({hs_b, pop_b})
                2'b10:   out_b <= out_b + CW'(1);
                2'b01:   out_b <= out_b - CW'(1);
                default: out_b <= out_b;
            endcase
        end
    end

    divmod_rsp_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (push_a),
        .push_data ({exit_tag.dz, div_result}),
        .pop       (pop_a),
        .empty     (empty_a),
        .head      (head_a)
    );

    divmod_rsp_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (push_b),
        .push_data ({exit_tag.dz, div_result}),
        .pop       (pop_b),
        .empty     (empty_b),
        .head      (head_b)
    );

    assign a.rsp_valid  = reset && !empty_a;
    assign a.rsp_result = head_a[31:0];
    assign a.rsp_dz     = head_a[32];
    assign b.rsp_valid  = reset && !empty_b;
    assign b.rsp_result = head_b[31:0];
    assign b.rsp_dz     = head_b[32];

    always_comb begin
        any_tag = issue_tag.valid;
        for (int i = 0; i < LAT; i++) begin
            any_tag = any_tag || tags[i].valid;
        end
        busy = reset && (any_tag || !empty_a || !empty_b);
    end

endmodule

// File: tb/tb_divmod_arbiter.sv
// Bench for divmod_arbiter: models the external divider and predicts every handshake,
// response and status flag from queues of accepted operations.
module tb_divmod_arbiter;

    localparam int DEPTH = 8;
    localparam int LAT   = 5;

    logic        clk;
    logic        reset;
    logic        div_valid_in, div_mode, div_valid_out, busy, protocol_err, inject;
    logic [31:0] div_dividend, div_result;
    logic [15:0] div_divisor;

    divmod_arbiter_if a_if ();
    divmod_arbiter_if b_if ();

    divmod_arbiter #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .a             (a_if),
        .b             (b_if),
        .div_valid_in  (div_valid_in),
        .div_mode      (div_mode),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_valid_out (div_valid_out),
        .div_result    (div_result),
        .busy          (busy),
        .protocol_err  (protocol_err)
    );

    typedef struct packed { logic v; logic [31:0] r; } dstage_t;
    typedef struct { bit v; bit mode; logic [31:0] dd; logic [15:0] ds; } req_t;
    typedef struct { logic [32:0] data; int due; } exp_t;
    typedef struct { bit ga; bit gb; bit rva; bit rvb; logic [32:0] da; logic [32:0] db; int cyc; } obs_t;
    typedef struct { logic [31:0] dd; logic [15:0] ds; bit mode; logic [31:0] exp_res; bit exp_dz; } vec_t;

    dstage_t     dpipe [LAT];
    exp_t        qa[$];
    exp_t        qb[$];
    bit          last_b, prev_g, exp_perr;
    logic [31:0] prev_dd;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divide by zero yields all-ones quotient and the dividend as remainder.
    function automatic logic [31:0] div_fn(input bit mode, input logic [31:0] dd, input logic [15:0] ds);
        if (ds == 16'd0) return mode ? dd : 32'hFFFF_FFFF;
        return mode ? (dd % {16'd0, ds}) : (dd / {16'd0, ds});
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
        end else begin
            dpipe[0] <= '{v: div_valid_in, r: div_fn(div_mode, div_dividend, div_divisor)};
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end

    assign div_valid_out = dpipe[LAT-1].v | inject;
    assign div_result    = dpipe[LAT-1].r;

    function automatic req_t mk_req(input bit v, input bit mode, input logic [31:0] dd, input logic [15:0] ds);
        req_t r;
        r.v = v; r.mode = mode; r.dd = dd; r.ds = ds;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // One clock of stimulus: drive after the edge, compare at the falling edge, update the model.
    task automatic applyStimulus(input req_t ra, input req_t rb, input bit arr, input bit brr, output obs_t o);
        bit ea, eb, ga, gb, erva, ervb;
        a_if.req_valid = ra.v; a_if.req_mode = ra.mode; a_if.req_dividend = ra.dd; a_if.req_divisor = ra.ds;
        b_if.req_valid = rb.v; b_if.req_mode = rb.mode; b_if.req_dividend = rb.dd; b_if.req_divisor = rb.ds;
        a_if.rsp_ready = arr;
        b_if.rsp_ready = brr;
        @(negedge clk);
        ea = ra.v && (qa.size() < DEPTH);
        eb = rb.v && (qb.size() < DEPTH);
        ga = ea && (!eb || last_b);
        gb = eb && !ga;
        o.ga = a_if.req_ready; o.gb = b_if.req_ready;
        o.rva = a_if.rsp_valid; o.rvb = b_if.rsp_valid;
        o.da = {a_if.rsp_dz, a_if.rsp_result}; o.db = {b_if.rsp_dz, b_if.rsp_result};
        o.cyc = cyc;
        checkOutput("a_req_ready", a_if.req_ready, ga);
        checkOutput("b_req_ready", b_if.req_ready, gb);
        checkOutput("busy", busy, (qa.size() + qb.size()) != 0);
        checkOutput("protocol_err", protocol_err, exp_perr);
        checkOutput("div_valid_in", div_valid_in, prev_g);
        if (prev_g) checkOutput("div_dividend", div_dividend, prev_dd);
        erva = (qa.size() != 0) && (qa[0].due <= cyc);
        ervb = (qb.size() != 0) && (qb[0].due <= cyc);
        checkOutput("a_rsp_valid", a_if.rsp_valid, erva);
        checkOutput("b_rsp_valid", b_if.rsp_valid, ervb);
        if (erva) begin
            checkOutput("a_rsp_data", o.da, qa[0].data);
            if (arr) qa.delete(0);
        end
        if (ervb) begin
            checkOutput("b_rsp_data", o.db, qb[0].data);
            if (brr) qb.delete(0);
        end
        prev_g  = ga || gb;
        prev_dd = ga ? ra.dd : rb.dd;
        if (ga) begin
            qa.push_back('{{(ra.ds == 16'd0), div_fn(ra.mode, ra.dd, ra.ds)}, cyc + 2 + LAT});
            last_b = 1'b0;
        end
        if (gb) begin
            qb.push_back('{{(rb.ds == 16'd0), div_fn(rb.mode, rb.dd, rb.ds)}, cyc + 2 + LAT});
            last_b = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Single-edge reset pulse with requests pending, so gated outputs are really exercised.
    task automatic doReset();
        reset = 1'b0;
        inject = 1'b0;
        a_if.req_valid = 1'b1; b_if.req_valid = 1'b1;
        a_if.rsp_ready = 1'b1; b_if.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_a_req_ready", a_if.req_ready, 1'b0);
        checkOutput("rst_b_req_ready", b_if.req_ready, 1'b0);
        checkOutput("rst_a_rsp_valid", a_if.rsp_valid, 1'b0);
        checkOutput("rst_b_rsp_valid", b_if.rsp_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_if.req_valid = 1'b0; b_if.req_valid = 1'b0;
        qa.delete(); qb.delete();
        last_b = 1'b1; prev_g = 1'b0; exp_perr = 1'b0;
        @(negedge clk);
        checkOutput("rst_div_valid_in", div_valid_in, 1'b0);
        checkOutput("rst_div_dividend", div_dividend, 32'd0);
        checkOutput("rst_div_divisor", div_divisor, 16'd0);
        checkOutput("rst_protocol_err", protocol_err, 1'b0);
        checkOutput("rst_busy_after", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        obs_t o;
        req_t idle;
        idle = mk_req(0, 0, 0, 0);
        for (int i = 0; i < 80 && (qa.size() + qb.size()) != 0; i++) applyStimulus(idle, idle, 1, 1, o);
        checkOutput("drain_empty", qa.size() + qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl [8];
        obs_t o;
        req_t idle, ra, rb;
        int   hs_cyc, cnt;
        bit   seen;
        logic [32:0] got;

        tbl[0] = '{32'd100,        16'd7,      1'b0, 32'd14,         1'b0};
        tbl[1] = '{32'd100,        16'd7,      1'b1, 32'd2,          1'b0};
        tbl[2] = '{32'd5,          16'd0,      1'b0, 32'hFFFF_FFFF,  1'b1};
        tbl[3] = '{32'd5,          16'd0,      1'b1, 32'd5,          1'b1};
        tbl[4] = '{32'hFFFF_FFFF,  16'd1,      1'b0, 32'hFFFF_FFFF,  1'b0};
        tbl[5] = '{32'hFFFF_FFFF,  16'hFFFF,   1'b0, 32'h0001_0001,  1'b0};
        tbl[6] = '{32'd12345,      16'h0100,   1'b1, 32'd57,         1'b0};
        tbl[7] = '{32'd0,          16'd3,      1'b0, 32'd0,          1'b0};

        idle = mk_req(0, 0, 0, 0);
        inject = 1'b0;
        doReset();

        // Single operations alternating between requesters, with hand-computed results.
        for (int i = 0; i < 8; i++) begin
            ra = i[0] ? idle : mk_req(1, tbl[i].mode, tbl[i].dd, tbl[i].ds);
            rb = i[0] ? mk_req(1, tbl[i].mode, tbl[i].dd, tbl[i].ds) : idle;
            applyStimulus(ra, rb, 1, 1, o);
            hs_cyc = o.cyc;
            seen = 1'b0;
            got = '0;
            for (int k = 0; k < 30 && !seen; k++) begin
                applyStimulus(idle, idle, 1, 1, o);
                if (i[0] ? o.rvb : o.rva) begin
                    seen = 1'b1;
                    got = i[0] ? o.db : o.da;
                    checkOutput("tbl_latency", o.cyc - hs_cyc, 2 + LAT);
                end
            end
            checkOutput("tbl_seen", seen, 1'b1);
            checkOutput("tbl_result", got, {tbl[i].exp_dz, tbl[i].exp_res});
            drain();
        end

        // Both requesters contending: grants alternate starting with A.
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mk_req(1, 0, 32'd1000 + k, 16'd7), mk_req(1, 1, 32'd2000 + k, 16'd9), 1, 1, o);
            checkOutput("rr_grant_a", o.ga, (k % 2) == 0);
            checkOutput("rr_grant_b", o.gb, (k % 2) == 1);
        end
        drain();

        // B streams with its response path stalled: credits cap acceptance at DEPTH.
        doReset();
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(idle, mk_req(1, k[0], 32'd50 + k, 16'd3), 1, 0, o);
            cnt += int'(o.gb);
        end
        checkOutput("credit_accepts", cnt, DEPTH);
        checkOutput("credit_ready_low", o.gb, 1'b0);
        applyStimulus(idle, mk_req(1, 0, 32'd77, 16'd3), 1, 1, o);
        checkOutput("credit_pop_cycle_ready", o.gb, 1'b0);
        checkOutput("credit_pop_valid", o.rvb, 1'b1);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(idle, mk_req(1, 0, 32'd80 + k, 16'd3), 1, 0, o);
            cnt += int'(o.gb);
        end
        checkOutput("credit_one_more", cnt, 1);
        drain();

        // Random traffic against the reference model.
        doReset();
        for (int n = 0; n < 400; n++) begin
            ra = mk_req($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom,
                        ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom));
            rb = mk_req($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom,
                        ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom));
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
        end
        drain();

        // Reset with work in flight drops it; a stray return afterwards is flagged.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mk_req(1, 0, 32'd300 + k, 16'd7), mk_req(1, 1, 32'd400 + k, 16'd7), 1, 1, o);
        end
        doReset();
        for (int k = 0; k < 12; k++) applyStimulus(idle, idle, 1, 1, o);
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        exp_perr = 1'b1;
        @(negedge clk);
        checkOutput("stray_protocol_err", protocol_err, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) applyStimulus(idle, idle, 1, 1, o);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divmod_arbiter.md
DIVMOD_ARBITER -- requirements
Module: divmod_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set response FIFO entries per requester (power of two, 2..16).
REQ-002 Parameter LAT, default 5, SHALL set divider latency in cycles, div_valid_in to div_valid_out.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-low; reset is asserted when low.
REQ-005 a_req_valid, b_req_valid  input  1 each  requester A/B has an operation pending.
REQ-006 a_req_ready, b_req_ready  output  1 each  operation accepted this cycle.
REQ-007 a_req_mode, b_req_mode  input  1 each  0 = quotient, 1 = remainder.
REQ-008 a_req_dividend, b_req_dividend  input  32 each; a_req_divisor, b_req_divisor  input  16 each.
REQ-009 a_rsp_valid, b_rsp_valid  output  1 each; a_rsp_ready, b_rsp_ready  input  1 each  response handshake.
REQ-010 a_rsp_result, b_rsp_result  output  32 each; a_rsp_dz, b_rsp_dz  output  1 each  divisor-was-zero flag.
REQ-011 div_valid_in, div_mode  output  1 each; div_dividend  output  32; div_divisor  output  16  divider issue port, all registered.
REQ-012 div_valid_out  input  1; div_result  input  32  divider return port.
REQ-013 busy  output  1  any operation in flight or buffered; protocol_err  output  1  sticky error flag.

Function
REQ-014 A request SHALL be eligible only if its req_valid is high and its outstanding count (in flight plus FIFO occupancy) is below DEPTH.
REQ-015 At most one request SHALL be granted per cycle: if one is eligible, grant it; if both are, grant the one not granted last; the last-grant pointer SHALL update only on a grant.
REQ-016 req_ready SHALL be high only in the cycle of a grant to that requester; handshake = valid && ready.
REQ-017 On a handshake at cycle N, div_valid_in SHALL be high in cycle N+1 with div_mode/div_dividend/div_divisor equal to the granted fields; otherwise div_valid_in SHALL be 0 and data held.
REQ-018 A LAT-deep tag shift register aligned with div_valid_in SHALL carry {valid, requester id, dz}; dz = (divisor == 0).
REQ-019 When div_valid_out is high and the tag exiting the shift register is valid, div_result and dz SHALL be written to that requester's FIFO in the same cycle.
REQ-020 When div_valid_out is high with no valid exiting tag, or a valid tag exits without div_valid_out, the result SHALL be discarded and protocol_err SHALL be set until reset.
REQ-021 rsp_valid SHALL mirror FIFO non-empty; pop on rsp_valid && rsp_ready; rsp_result and rsp_dz SHALL be the FIFO head, held stable while rsp_ready is low.
REQ-022 Response latency: handshake at N, div_valid_out at N+1+LAT, rsp_valid high at N+2+LAT if the FIFO was empty.
REQ-023 Outstanding count SHALL increment on handshake and decrement on pop; simultaneous handshake and pop SHALL leave it unchanged; the credit rule guarantees no FIFO overflow.
REQ-024 Responses per requester SHALL return in acceptance order; no reordering across the shared pipeline affects a single requester.
REQ-025 busy SHALL be high whenever any tag is valid or any FIFO is non-empty.

Reset
REQ-026 While reset is low: all req_ready, rsp_valid, div_valid_in, busy and protocol_err SHALL be 0; div_* data 0; FIFOs and tags cleared; outstanding counts 0; last-grant pointer = B so A wins the first tie.
REQ-027 Reset mid-operation SHALL drop all in-flight and buffered results; divider returns after reset with no valid tag SHALL be discarded and SHALL set protocol_err.

Structure
REQ-028 A shared package SHALL hold the requester-id enum (REQ_A, REQ_B), the tag record type and the DEPTH/LAT defaults.
REQ-029 One sub-module, divmod_rsp_fifo (synchronous, DEPTH entries of 33 bits, registered count), SHALL be instantiated once per requester.
REQ-030 The divider itself SHALL NOT be instantiated inside this block; it connects through the div_* ports.

Verification
REQ-031 A only, dividend 100, divisor 7, mode 0, handshake at cycle 10 -> div_valid_in at 11; a_rsp_valid at 17, result 14, dz 0.
REQ-032 A and B valid together for 4 cycles -> grants A,B,A,B; each requester receives its two results in order.
REQ-033 b_rsp_ready held low, B streams requests -> exactly 8 accepted, b_req_ready then stays low until one pop, then one more grant.
REQ-034 Divisor 0, dividend 5 -> rsp_dz = 1, result passed through unchanged from div_result.
REQ-035 Reset pulled low for 1 cycle with 3 operations in flight -> no rsp_valid afterwards, busy 0; an injected stray div_valid_out sets protocol_err.
